lfsr_period_checker: RTL and testbench
======================================

# lfsr_period_checker

Downstream monitor for the LFSR stage. It samples the LFSR's `computed_value` every clock and, on request, measures the sequence period from a captured reference value. It flags maximal-length sequences, lock-up (period 1) and sequences that never return to the reference value. It sits beside the LFSR, so benches and on-chip self-test can qualify a `taps`/`reset_value` choice without a human reading `$monitor` logs.

## Interface

Parameters:
- `WIDTH`, default 3, LFSR state width in bits.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `value`  in  WIDTH  LFSR output, sampled every rising edge.
- `start`  in  1  arm one measurement; sampled only in IDLE or a final state.
- `busy`  out  1  high while measuring.
- `done`  out  1  measurement finished with a match; held until next accepted `start`.
- `period`  out  WIDTH+1  measured period; 0 when none.
- `maximal`  out  1  `period == 2**WIDTH-1`; valid with `done`.
- `lockup`  out  1  `period == 1`; valid with `done`.
- `timeout`  out  1  reference not seen again within `2**WIDTH` edges; held until next accepted `start`.

## Operation

- States: IDLE, COUNT, DONE, TIMEOUT.
- IDLE, DONE or TIMEOUT with `start=1` at an edge:
  - `ref <= value`, `cnt <= 0`.
  - Clear `done`, `timeout`, `period`, `maximal` and `lockup`.
  - Go to COUNT, `busy <= 1`.
- COUNT, at each edge:
  - `n = cnt+1`.
  - If `value == ref`: `period <= n`, set `maximal` and `lockup` per their definitions, `done <= 1`, `busy <= 0`, go to DONE.
  - Else if `n == 2**WIDTH`: `timeout <= 1`, `period <= 0`, `busy <= 0`, go to TIMEOUT.
  - Else `cnt <= n`.
- `start` is ignored in COUNT.
- `cnt` is WIDTH+1 bits and never wraps; the terminal value is `2**WIDTH`.
- The reference value is arbitrary, including 0. An all-zero reference held constant yields period 1 and `lockup`.
- Asynchronous `reset` low at any time: state IDLE; `ref`, `cnt` and all outputs go to 0.

## Timing

- Reset values: `busy`, `done`, `period`, `maximal`, `lockup` and `timeout` are all 0.
- Capture happens at the edge where `start` is accepted (edge k).
- If `value` first equals `ref` again at edge k+p, then after edge k+p: `done=1` and `period=p`.
- If there is no match, `timeout=1` after edge k+2**WIDTH.
- All outputs are registered; there is no combinational path from input to output.
- `start` held high after a result restarts a measurement at the next edge. The result is therefore visible for exactly one cycle.

## Configuration

- `LFSR_VISIT_MAP_EN` defined: a `2**WIDTH`-bit visited map is cleared at capture, and `value` marks its entry at each COUNT edge.
  - If a non-reference value is seen a second time, `timeout` asserts at that edge, with the same state and output effects as a timeout. This gives early detection of sequences with a tail.
  - The reference match takes priority over a repeat at the same edge.
- `LFSR_VISIT_MAP_EN` undefined: no map. A tail is detected only by the `2**WIDTH` timeout.

## Structure

- Shared package `lfsr_pkg` holds:
  - the state enum `lfsr_chk_state_t` (IDLE, COUNT, DONE, TIMEOUT);
  - the width helper constant `LFSR_CHK_CNT_W = WIDTH+1` function.
- One sub-module, `lfsr_visit_map`, is instantiated only under `LFSR_VISIT_MAP_EN`.
  - Ports: `clock`, `reset`, `clear`, `mark`, `value`, `seen`.
  - `seen` is combinational: "`value` already marked".

## Test plan

- Constant `value=0`, start at edge 10 -> after edge 11: `done=1`, `period=1`, `lockup=1`, `maximal=0`.
- Repeating 7,3,1,4,2,5,6 with start while `value=7` -> `done` after 7 edges, `period=7`, `maximal=1`.
- Sequence 5 then 1,2,1,2,… with start on 5:
  - Macro off: `timeout=1` after 8 edges, `period=0`.
  - Macro on: `timeout=1` at the edge presenting the second 1, which is edge 3.
- `start` pulsed again during COUNT of the 7-cycle sequence -> ignored; result is still `period=7` at the original edge.
- Drop `reset` low mid-COUNT for 1 ns -> all outputs 0 immediately and state IDLE. After reset is released, a new start measures correctly.
- Connected to `lfsr_3bit` (taps 3'b110, reset_value 3'b111), start 5 edges after release -> exactly one of `done` or `timeout` asserts within 8 edges. If `done`, `period` is in 1..7.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR period checker: FSM state encoding and counter width helper.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } lfsr_chk_state_t;

   // The period counter needs one extra bit so it can reach 2**WIDTH without wrapping.
   function automatic int LFSR_CHK_CNT_W(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/lfsr_visit_map.sv
// One-bit-per-state visited map used to spot an LFSR sequence that repeats before returning to the reference.
module lfsr_visit_map
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 3
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             mark,
   input  logic [WIDTH-1:0] value,
   output logic             seen
);

   localparam int DEPTH = 1 << WIDTH;

   logic [DEPTH-1:0] map_q;
   logic [DEPTH-1:0] map_d;

   always_comb begin
      map_d = map_q;
      if (clear) begin
         map_d = '0;
      end else if (mark) begin
         map_d[value] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         map_q <= '0;
      end else begin
         map_q <= map_d;
      end
   end

   assign seen = map_q[value];

endmodule

// File: rtl/lfsr_period_checker.sv
// Measures the period of an LFSR output from a captured reference value.
// Define LFSR_VISIT_MAP_EN to add early detection of sequences that repeat without returning.
//
// state   | meaning
// IDLE    | no measurement since reset
// COUNT   | reference captured, counting edges until it reappears
// DONE    | reference reappeared, period/maximal/lockup valid
// TIMEOUT | reference not seen again (or a repeat seen with the map)
module lfsr_period_checker
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 3
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] value,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   period,
   output logic             maximal,
   output logic             lockup,
   output logic             timeout
);

   localparam int                CNT_W      = LFSR_CHK_CNT_W(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_TERM   = CNT_ONE << WIDTH;
   localparam logic [CNT_W-1:0]  PERIOD_MAX = CNT_TERM - CNT_ONE;

   lfsr_chk_state_t   state_q, state_d;
   logic [WIDTH-1:0]  ref_q, ref_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_next;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              maximal_q, maximal_d;
   logic              lockup_q, lockup_d;
   logic              timeout_q, timeout_d;
   logic              seen;

   assign cnt_next = cnt_q + CNT_ONE;

`ifdef LFSR_VISIT_MAP_EN
   logic capture;
   logic mark;

   assign capture = (state_q != COUNT) && start;
   assign mark    = (state_q == COUNT);

   lfsr_visit_map #(
      .WIDTH (WIDTH)
   ) u_visit_map (
      .clock (clock),
      .reset (reset),
      .clear (capture),
      .mark  (mark),
      .value (value),
      .seen  (seen)
   );
`else
   assign seen = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ref_d     = ref_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = done_q;
      period_d  = period_q;
      maximal_d = maximal_q;
      lockup_d  = lockup_q;
      timeout_d = timeout_q;

      case (state_q)
         IDLE, DONE, TIMEOUT: begin
            if (start) begin
               ref_d     = value;
               cnt_d     = '0;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               period_d  = '0;
               maximal_d = 1'b0;
               lockup_d  = 1'b0;
               busy_d    = 1'b1;
               state_d   = COUNT;
            end
         end
         COUNT: begin
            // A reference match wins over a repeat reported by the map at the same edge.
            if (value == ref_q) begin
               period_d  = cnt_next;
               maximal_d = (cnt_next == PERIOD_MAX);
               lockup_d  = (cnt_next == CNT_ONE);
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = DONE;
            end else if ((cnt_next == CNT_TERM) || seen) begin
               timeout_d = 1'b1;
               period_d  = '0;
               busy_d    = 1'b0;
               state_d   = TIMEOUT;
            end else begin
               cnt_d = cnt_next;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ref_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         period_q  <= '0;
         maximal_q <= 1'b0;
         lockup_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ref_q     <= ref_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         period_q  <= period_d;
         maximal_q <= maximal_d;
         lockup_q  <= lockup_d;
         timeout_q <= timeout_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign period  = period_q;
   assign maximal = maximal_q;
   assign lockup  = lockup_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Scoreboard bench for lfsr_period_checker: value streams are scanned up front for expected results.
`timescale 1ns/1ps
module tb_lfsr_period_checker;

   localparam int W     = 3;
   localparam int DEPTH = 1 << W;

   logic         clock = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] value = '0;
   logic         busy, done, maximal, lockup, timeout;
   logic [W:0]   period;

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;

   typedef struct {
      bit is_done;
      int per;
      int at_edge;
   } exp_t;

   exp_t exp_q[$];

   lfsr_period_checker #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset   (rst_n),
      .value   (value),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .period  (period),
      .maximal (maximal),
      .lockup  (lockup),
      .timeout (timeout)
   );

   always #5 clock = ~clock;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at edge %0d", name, act, req, edge_cnt);
      end
   endtask

   // Reference: a start at stream index i is accepted only once the previous result edge has passed;
   // the period is the distance to the next occurrence of the captured value.
   task automatic model_stream(input logic [W-1:0] v[$], input bit st[$], input int base);
      int busy_until;
      exp_t e;
`ifdef LFSR_VISIT_MAP_EN
      bit seen_set[DEPTH];
`endif
      busy_until = -1;
      for (int i = 0; i < v.size(); i++) begin
         if (st[i] && i > busy_until) begin
            e.is_done = 1'b0;
            e.per     = 0;
            e.at_edge = base + i + DEPTH;
`ifdef LFSR_VISIT_MAP_EN
            foreach (seen_set[j]) seen_set[j] = 1'b0;
`endif
            for (int p = 1; p <= DEPTH; p++) begin
               if (v[i+p] == v[i]) begin
                  e.is_done = 1'b1;
                  e.per     = p;
                  e.at_edge = base + i + p;
                  break;
               end
`ifdef LFSR_VISIT_MAP_EN
               if (seen_set[v[i+p]]) begin
                  e.at_edge = base + i + p;
                  break;
               end
               seen_set[v[i+p]] = 1'b1;
`endif
            end
            exp_q.push_back(e);
            busy_until = e.at_edge - base;
         end
      end
   endtask

   task automatic run_stream(input logic [W-1:0] v_in[$], input bit st_in[$], input int abort_at);
      logic [W-1:0] v[$];
      bit           st[$];
      int           base;
      v  = v_in;
      st = st_in;
      for (int j = 0; j <= DEPTH; j++) begin
         v.push_back(W'($urandom_range(0, DEPTH-1)));
         st.push_back(1'b0);
      end
      @(posedge clock); #1;
      base = edge_cnt + 1;
      if (abort_at < 0) model_stream(v, st, base);
      for (int i = 0; i < v.size(); i++) begin
         value = v[i];
         start = st[i];
         if (i == abort_at) begin
            chk("busy_before_reset", int'(busy), 1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_period", int'(period), 0);
            chk("rst_maximal", int'(maximal), 0);
            chk("rst_lockup", int'(lockup), 0);
            chk("rst_timeout", int'(timeout), 0);
            exp_q.delete();
            rst_n = 1'b1;
            start = 1'b0;
            return;
         end
         @(posedge clock); #1;
      end
      start = 1'b0;
   endtask

   bit busy_prev = 1'b0;

   always @(negedge clock or negedge rst_n) begin
      exp_t e;
      if (!rst_n) begin
         busy_prev = 1'b0;
      end else begin
         if (busy_prev && !busy) begin
            chk("result_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("result_edge", edge_cnt, e.at_edge);
               chk("one_of_done_timeout", int'(done) + int'(timeout), 1);
               chk("done", int'(done), int'(e.is_done));
               chk("timeout", int'(timeout), int'(!e.is_done));
               chk("period", int'(period), e.per);
               chk("maximal", int'(maximal), int'(e.is_done && e.per == DEPTH-1));
               chk("lockup", int'(lockup), int'(e.is_done && e.per == 1));
            end
         end
         busy_prev = busy;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at edge %0d", edge_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] v[$];
      bit           st[$];
      logic [W-1:0] s;
      logic [W-1:0] seven[7];
      seven = '{3'd7, 3'd3, 3'd1, 3'd4, 3'd2, 3'd5, 3'd6};

      #3;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_period", int'(period), 0);
      chk("reset_maximal", int'(maximal), 0);
      chk("reset_lockup", int'(lockup), 0);
      chk("reset_timeout", int'(timeout), 0);
      #14 rst_n = 1'b1;
      repeat (8) @(posedge clock);

      // constant zero: lockup
      v.delete(); st.delete();
      for (int i = 0; i < 4; i++) begin v.push_back(3'd0); st.push_back(i == 0); end
      run_stream(v, st, -1);

      // maximal 7-cycle sequence
      v.delete(); st.delete();
      for (int i = 0; i < 14; i++) begin v.push_back(seven[i % 7]); st.push_back(i == 0); end
      run_stream(v, st, -1);

      // tail: 5 then 1,2,1,2...
      v.delete(); st.delete();
      v.push_back(3'd5); st.push_back(1'b1);
      for (int i = 0; i < 8; i++) begin v.push_back((i % 2 == 0) ? 3'd1 : 3'd2); st.push_back(1'b0); end
      run_stream(v, st, -1);

      // start re-pulsed during COUNT is ignored
      v.delete(); st.delete();
      for (int i = 0; i < 14; i++) begin v.push_back(seven[i % 7]); st.push_back(i == 0 || i == 3); end
      run_stream(v, st, -1);

      // reset mid-count, then a fresh measurement
      v.delete(); st.delete();
      for (int i = 0; i < 14; i++) begin v.push_back(seven[i % 7]); st.push_back(i == 0); end
      run_stream(v, st, 3);
      run_stream(v, st, -1);

      // start held high: back-to-back restarts on a period-2 pattern
      v.delete(); st.delete();
      for (int i = 0; i < 20; i++) begin v.push_back((i % 2 == 0) ? 3'd6 : 3'd1); st.push_back(1'b1); end
      run_stream(v, st, -1);

      // behavioural 3-bit LFSR, taps 110, seed 111, start 5 edges in
      v.delete(); st.delete();
      s = 3'b111;
      for (int i = 0; i < 20; i++) begin
         v.push_back(s);
         st.push_back(i == 5);
         s = {s[1:0], ^(s & 3'b110)};
      end
      run_stream(v, st, -1);

      // randomized streams over a small alphabet
      for (int n = 0; n < 40; n++) begin
         int hi;
         v.delete(); st.delete();
         hi = $urandom_range(0, DEPTH-1);
         for (int i = 0; i < 24; i++) begin
            v.push_back(W'($urandom_range(0, hi)));
            st.push_back($urandom_range(0, 2) == 0);
         end
         run_stream(v, st, -1);
      end

      for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clock);
      chk("pending_results", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
